nn_wgt_load_ctrl: RTL

Sequencing controller in front of the RAM-based multi-layer network. It accepts weight-load commands plus a weight stream and writes the words into the selected layer's weight RAM through the layer-select/addr/we/din weight port. On a run command it drives the network's req/ack/ready start handshake and reports completion. It is the only master of the network's weight port and start handshake.

---
 rtl/nn_wgt_load_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nn_wgt_load_ctrl.sv
// Weight-load and run sequencer for the RAM-based multi-layer network.
// Streams weight words into the selected layer RAM and drives the req/ack/ready start handshake.
module nn_wgt_load_ctrl #(
    parameter  int NumLayers    = 3,
    parameter  int DataWidth    = 8,
    parameter  int WgtAddrWidth = 11,
    localparam int LW           = (NumLayers > 1) ? $clog2(NumLayers) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [LW-1:0]           cmd_layer_i,
    input  logic [WgtAddrWidth:0]   cmd_len_i,
    input  logic                    wgt_valid_i,
    output logic                    wgt_ready_o,
    input  logic [DataWidth-1:0]    wgt_data_i,
    input  logic                    run_valid_i,
    output logic                    run_ready_o,
    output logic                    done_o,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic                    err_clr_i,
    output logic [LW-1:0]           ram_index_o,
    output logic [WgtAddrWidth-1:0] wgt_ram_addr_o,
    output logic                    wgt_ram_we_o,
    output logic [DataWidth-1:0]    wgt_ram_dout_o,
    output logic                    nn_req_o,
    input  logic                    nn_ack_i,
    input  logic                    nn_ready_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        RUN_REQ  = 2'd2,
        RUN_WAIT = 2'd3
    } state_e;

    localparam logic [WgtAddrWidth:0] MaxLen = {1'b1, {WgtAddrWidth{1'b0}}};
    localparam logic [WgtAddrWidth:0] OneLen = {{WgtAddrWidth{1'b0}}, 1'b1};

    state_e                  state_q;
    logic [WgtAddrWidth:0]   cnt_q;
    logic [WgtAddrWidth:0]   len_q;
    logic [LW-1:0]           index_q;
    logic [WgtAddrWidth-1:0] addr_q;
    logic [DataWidth-1:0]    dout_q;
    logic                    we_q;
    logic                    req_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    err_q;
    logic                    cmd_illegal;
    logic                    beat;

    assign cmd_illegal = (32'(cmd_layer_i) >= NumLayers) || (cmd_len_i > MaxLen);
    assign beat        = wgt_valid_i && (state_q == LOAD);

    // The ready strobes are gated by reset so every output reads 0 while reset is held.
    assign cmd_ready_o    = reset_ni && (state_q == IDLE);
    assign run_ready_o    = reset_ni && (state_q == IDLE);
    assign wgt_ready_o    = (state_q == LOAD);
    assign done_o         = done_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;
    assign ram_index_o    = index_q;
    assign wgt_ram_addr_o = addr_q;
    assign wgt_ram_we_o   = we_q;
    assign wgt_ram_dout_o = dout_q;
    assign nn_req_o       = req_q;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            index_q <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;

            if (state_q == IDLE && cmd_valid_i && cmd_illegal) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        if (!cmd_illegal && cmd_len_i != '0) begin
                            index_q <= cmd_layer_i;
                            len_q   <= cmd_len_i;
                            cnt_q   <= '0;
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                    end else if (run_valid_i) begin
                        req_q   <= 1'b1;
                        state_q <= RUN_REQ;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q[WgtAddrWidth-1:0];
                        dout_q <= wgt_data_i;
                        cnt_q  <= cnt_q + OneLen;
                        if (cnt_q == len_q - OneLen) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RUN_REQ: begin
                    // A ready arriving together with the ack is not consumed here.
                    if (nn_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= RUN_WAIT;
                    end
                end
                RUN_WAIT: begin
                    if (nn_ready_i) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
